axis_rr_arbiter: RTL and testbench

AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

---
 rtl/rr_priority_select.sv | 26 ++
 rtl/axis_rr_arbiter.sv | 66 ++++++
 tb/tb_axis_rr_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/rr_priority_select.sv
// rr_priority_select: cyclic priority search over a request vector starting just above the last grant
// ports: req (request per stream), last (previous grant) -> found (any request), sel (chosen index)
module rr_priority_select #(
  parameter int COUNT = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [COUNT-1:0]     req,
  input  logic [IDX_WIDTH-1:0] last,
  output logic                 found,
  output logic [IDX_WIDTH-1:0] sel
);
  logic [COUNT-1:0] upper, pick, onehot;
  logic [IDX_WIDTH-1:0] part [COUNT+1];
  // requests strictly above last win; otherwise wrap to the lowest request
  always_comb begin
    upper = req & ~((COUNT'(1) << ((IDX_WIDTH+1)'(last) + 1'b1)) - COUNT'(1));
    pick = |upper ? upper : req;
    onehot = pick & (~pick + COUNT'(1));
    found = |req;
  end
  assign part[0] = '0;
  for (genvar i = 0; i < COUNT; i++) begin : g_enc
    assign part[i+1] = part[i] | (onehot[i] ? IDX_WIDTH'(i) : '0);
  end
  assign sel = part[COUNT];
endmodule

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-level round-robin arbiter merging COUNT AXI-stream inputs into one registered output
// ports: clock, resetn (sync, active-low); idata/ivalid/ilast/iready per input stream;
//        odata/olast/ovalid/oready output stream; ogrant granted index; obusy high while locked to a packet
module axis_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int COUNT = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [COUNT*WIDTH-1:0] idata,
  input  logic [COUNT-1:0]       ivalid,
  input  logic [COUNT-1:0]       ilast,
  output logic [COUNT-1:0]       iready,
  output logic [WIDTH-1:0]       odata,
  output logic                   olast,
  output logic                   ovalid,
  input  logic                   oready,
  output logic [IDX_WIDTH-1:0]   ogrant,
  output logic                   obusy
);
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;
  state_t state, state_n;
  logic [IDX_WIDTH-1:0] last, last_n, grant_n, sel;
  logic [COUNT-1:0] gmask;
  logic found, take, xfer, beat_last;
  rr_priority_select #(.COUNT(COUNT), .IDX_WIDTH(IDX_WIDTH)) u_sel (
    .req(ivalid),
    .last(last),
    .found(found),
    .sel(sel)
  );
  // accept only when the output register is empty or draining this cycle
  always_comb begin
    gmask = COUNT'(1) << ogrant;
    take = state == LOCKED && (!ovalid || oready);
    iready = take ? gmask : '0;
    xfer = take && |(ivalid & gmask);
    beat_last = |(ilast & gmask);
    state_n = state == IDLE ? (found ? LOCKED : IDLE) : (xfer && beat_last ? IDLE : LOCKED);
    grant_n = state == IDLE && found ? sel : ogrant;
    last_n = xfer && beat_last ? ogrant : last;
  end
  assign obusy = state == LOCKED;
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
      last <= IDX_WIDTH'(COUNT - 1);
      ogrant <= '0;
      odata <= '0;
      olast <= 1'b0;
      ovalid <= 1'b0;
    end else begin
      state <= state_n;
      last <= last_n;
      ogrant <= grant_n;
      if (xfer) begin
        odata <= WIDTH'(idata >> (int'(ogrant) * WIDTH));
        olast <= beat_last;
        ovalid <= 1'b1;
      end else if (oready) begin
        ovalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: randomized and directed checks of axis_rr_arbiter against a packet-queue reference model
module tb_axis_rr_arbiter;
  localparam int W = 8;
  localparam int C = 4;
  localparam int IW = 2;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic [C*W-1:0] idata = '0;
  logic [C-1:0] ivalid = '0, ilast = '0, iready, rdy_s = '0;
  logic [W-1:0] odata;
  logic olast, ovalid, obusy;
  logic oready = 1'b0;
  logic [IW-1:0] ogrant;
  always #5 clock = ~clock;
  axis_rr_arbiter #(.WIDTH(W), .COUNT(C), .IDX_WIDTH(IW)) dut (
    .clock(clock), .resetn(resetn), .idata(idata), .ivalid(ivalid), .ilast(ilast), .iready(iready),
    .odata(odata), .olast(olast), .ovalid(ovalid), .oready(oready), .ogrant(ogrant), .obusy(obusy)
  );
  int checks = 0, passed = 0, cyc = 0, gap = 0, opct = 100;
  logic [W:0] src [C][$];
  logic [W:0] q[$];
  int out_cyc[$], dgrants[$];
  bit m_busy = 0, prev_busy = 0;
  int m_grant = 0, m_last = C - 1;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic add_pkt(int k, int n);
    for (int i = 0; i < n; i++) src[k].push_back({1'(i == n - 1), W'($urandom)});
  endtask
  function automatic bit pending();
    for (int k = 0; k < C; k++) if (src[k].size() != 0) return 1;
    return 0;
  endfunction
  task automatic step();
    logic [C-1:0] pop;
    bit rdy, inx, outx, hold;
    @(posedge clock);
    cyc++;
    pop = resetn ? (ivalid & rdy_s) : '0;
    if (!resetn) begin
      m_busy = 0; m_grant = 0; m_last = C - 1; q.delete();
    end else begin
      rdy = m_busy && (q.size() == 0 || oready);
      inx = rdy && ivalid[m_grant];
      outx = q.size() != 0 && oready;
      if (outx) void'(q.pop_front());
      if (inx) q.push_back({ilast[m_grant], idata[m_grant*W +: W]});
      if (!m_busy) begin
        for (int k = 1; k <= C; k++)
          if (!m_busy && ivalid[(m_last + k) % C]) begin
            m_busy = 1; m_grant = (m_last + k) % C;
          end
      end else if (inx && ilast[m_grant]) begin
        m_busy = 0; m_last = m_grant;
      end
    end
    for (int k = 0; k < C; k++) if (pop[k]) void'(src[k].pop_front());
    @(negedge clock);
    for (int k = 0; k < C; k++) begin
      hold = ivalid[k] && !pop[k];
      ivalid[k] = src[k].size() != 0 && (hold || $urandom_range(99) >= gap);
      if (ivalid[k]) begin
        idata[k*W +: W] = src[k][0][W-1:0];
        ilast[k] = src[k][0][W];
      end
    end
    oready = $urandom_range(99) < opct;
    #1;
    chk("iready", iready, (m_busy && (q.size() == 0 || oready)) ? (1 << m_grant) : 0);
    chk("ogrant", ogrant, m_grant);
    chk("obusy", obusy, m_busy);
    chk("ovalid", ovalid, q.size() != 0);
    if (q.size() != 0) chk("obeat", {olast, odata}, q[0]);
    if (ovalid && oready) out_cyc.push_back(cyc);
    if (obusy && !prev_busy) dgrants.push_back(ogrant);
    prev_busy = obusy;
    rdy_s = iready;
  endtask
  task automatic run_idle(int max);
    int n = 0;
    while ((pending() || q.size() != 0 || m_busy) && n < max) begin
      step();
      n++;
    end
    if (n >= max) chk("timeout", 0, 1);
  endtask
  task automatic do_reset();
    for (int k = 0; k < C; k++) src[k].delete();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
    dgrants.delete();
    out_cyc.delete();
  endtask
  initial begin
    logic [W:0] held;
    do_reset();
    chk("rst_ovalid", ovalid, 0);
    chk("rst_olast", olast, 0);
    chk("rst_odata", odata, 0);
    chk("rst_ogrant", ogrant, 0);
    chk("rst_obusy", obusy, 0);
    chk("rst_iready", iready, 0);
    gap = 0; opct = 100;
    add_pkt(2, 3);
    step();
    step();
    chk("t36_grant", ogrant, 2);
    run_idle(50);
    chk("t36_beats", out_cyc.size(), 3);
    if (out_cyc.size() == 3) chk("t36_consec", out_cyc[2] - out_cyc[0], 2);
    do_reset();
    for (int p = 0; p < 3; p++) for (int k = 0; k < C; k++) add_pkt(k, 2);
    run_idle(300);
    chk("t37_ngrants", dgrants.size(), 12);
    foreach (dgrants[i]) chk("t37_order", dgrants[i], i % C);
    do_reset();
    add_pkt(1, 5);
    for (int i = 0; i < 4; i++) step();
    opct = 0;
    step();
    held = {olast, odata};
    chk("t38_iready", iready[1], 0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t38_iready", iready[1], 0);
      chk("t38_ovalid", ovalid, 1);
      chk("t38_hold", {olast, odata}, held);
    end
    opct = 100;
    run_idle(50);
    chk("t38_beats", out_cyc.size(), 5);
    do_reset();
    add_pkt(3, 1);
    run_idle(50);
    dgrants.delete();
    add_pkt(0, 1);
    add_pkt(2, 1);
    run_idle(50);
    chk("t39_ngrants", dgrants.size(), 2);
    if (dgrants.size() == 2) begin
      chk("t39_wrap", dgrants[0], 0);
      chk("t39_next", dgrants[1], 2);
    end
    do_reset();
    add_pkt(1, 4);
    for (int i = 0; i < 4; i++) step();
    for (int k = 0; k < C; k++) src[k].delete();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("t40_ovalid", ovalid, 0);
    chk("t40_obusy", obusy, 0);
    chk("t40_ogrant", ogrant, 0);
    out_cyc.delete();
    for (int i = 0; i < 5; i++) step();
    chk("t40_noout", out_cyc.size(), 0);
    do_reset();
    for (int i = 0; i < 6; i++) add_pkt(0, 1);
    run_idle(100);
    chk("t41_beats", out_cyc.size(), 6);
    if (out_cyc.size() == 6) chk("t41_rate", out_cyc[5] - out_cyc[0], 10);
    do_reset();
    gap = 30; opct = 70;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) add_pkt($urandom_range(C - 1), $urandom_range(4, 1));
      step();
    end
    run_idle(3000);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
